// File: rtl/deser_pkg.sv
// deser_pkg: shared widths and output-buffer state type for the 1:8 deserializer.
package deser_pkg;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
endpackage

// File: rtl/deser_out_buf.sv
// deser_out_buf: output word register, par_valid FSM and parity_err register.
// Parity register exists only when DESER_PARITY_EN is defined.
module deser_out_buf
  import deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [0:WORD_W-1] data_i,
  input  logic              par_ready_i,
  output logic [0:WORD_W-1] par_out_o,
  output logic              par_valid_o,
  output logic              full_o
`ifdef DESER_PARITY_EN
  ,
  input  logic              perr_i,
  output logic              parity_err_o
`endif
);
  out_state_e        state_q, state_d;
  logic [0:WORD_W-1] data_q;
`ifdef DESER_PARITY_EN
  logic perr_q;
  assign parity_err_o = perr_q;
`endif
  always_comb begin
    state_d = load_i ? OUT_FULL : (state_q == OUT_FULL && par_ready_i) ? OUT_EMPTY : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
`ifdef DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load_i) data_q <= data_i;
`ifdef DESER_PARITY_EN
      if (load_i) perr_q <= perr_i;
`endif
    end
  end
  assign full_o      = state_q == OUT_FULL;
  assign par_valid_o = full_o;
  assign par_out_o   = data_q;
endmodule

// File: rtl/deser_1to8.sv
// deser_1to8: serial-to-parallel deserializer with a one-word output buffer.
// Define DESER_PARITY_EN for 9-bit words (8 data + even parity) and a parity_err output.
module deser_1to8
  import deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic              ser_ready,
  input  logic              clear,
  output logic [0:WORD_W-1] par_out,
  output logic              par_valid,
  input  logic              par_ready,
  output logic [CNT_W-1:0]  bit_cnt
`ifdef DESER_PARITY_EN
  ,
  output logic              parity_err
`endif
);
`ifdef DESER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);
`endif
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:WORD_W-1] asm_q, asm_d, asm_w;
  logic [2:0]        pos;
  logic              full, accept, done;
  assign ser_ready = !(cnt_q == LAST && full && !par_ready);
  assign accept    = ser_valid && ser_ready && !clear;
  assign done      = accept && cnt_q == LAST;
  assign pos       = MSB_FIRST ? cnt_q[2:0] : 3'd7 - cnt_q[2:0];
  // asm_w is the word including this cycle's bit, so the final bit reaches par_out on the same edge
  always_comb begin
    asm_w = asm_q;
    if (accept && cnt_q < CNT_W'(WORD_W)) asm_w[pos] = ser_in;
    asm_d = (clear || done) ? '0 : asm_w;
    cnt_d = (clear || done) ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end
  assign bit_cnt = cnt_q;
  deser_out_buf u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (done),
    .data_i      (asm_w),
    .par_ready_i (par_ready),
    .par_out_o   (par_out),
    .par_valid_o (par_valid),
    .full_o      (full)
`ifdef DESER_PARITY_EN
    ,
    .perr_i       (^asm_q ^ ser_in),
    .parity_err_o (parity_err)
`endif
  );
endmodule

// File: tb/tb_deser_1to8.sv
// tb_deser_1to8: random and directed stimulus on both bit orders against a bit-queue reference model.
module tb_deser_1to8;
`ifdef DESER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic ser_in = 1'b0, ser_valid = 1'b0, clear = 1'b0, par_ready = 1'b0;
  logic rdy_m, rdy_l, pv_m, pv_l;
  logic [0:7] po_m, po_l;
  logic [3:0] cnt_m, cnt_l;
`ifdef DESER_PARITY_EN
  logic pe_m, pe_l;
`endif
  int n_chk = 0, n_pass = 0;
  bit q[$];
  bit m_valid = 0, m_perr = 0;
  logic [7:0] m_wm = 8'h00, m_wl = 8'h00;

  always #5 clk = ~clk;

  deser_1to8 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(rdy_m),
    .clear(clear), .par_out(po_m), .par_valid(pv_m), .par_ready(par_ready), .bit_cnt(cnt_m)
`ifdef DESER_PARITY_EN
    , .parity_err(pe_m)
`endif
  );
  deser_1to8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(rdy_l),
    .clear(clear), .par_out(po_l), .par_valid(pv_l), .par_ready(par_ready), .bit_cnt(cnt_l)
`ifdef DESER_PARITY_EN
    , .parity_err(pe_l)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit m_ready();
    return !(q.size() == NB - 1 && m_valid && !par_ready);
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_perr = 0; m_wm = 8'h00; m_wl = 8'h00;
  endtask

  task automatic model_edge();
    bit acc, done;
    acc = !clear && ser_valid && m_ready();
    done = 0;
    if (clear) q.delete();
    else if (acc) begin
      q.push_back(ser_in);
      if (q.size() == NB) begin
        done = 1;
        m_perr = 0;
        foreach (q[i]) m_perr ^= q[i];
        for (int i = 0; i < 8; i++) begin
          m_wm[7 - i] = q[i];
          m_wl[i] = q[i];
        end
        q.delete();
      end
    end
    if (done) m_valid = 1;
    else if (par_ready) m_valid = 0;
  endtask

  task automatic check_outputs();
    chk("bit_cnt_m", 16'(cnt_m), 16'(q.size()));
    chk("bit_cnt_l", 16'(cnt_l), 16'(q.size()));
    chk("par_valid_m", 16'(pv_m), 16'(m_valid));
    chk("par_valid_l", 16'(pv_l), 16'(m_valid));
    chk("par_out_m", 16'(po_m), 16'(m_wm));
    chk("par_out_l", 16'(po_l), 16'(m_wl));
`ifdef DESER_PARITY_EN
    chk("parity_err_m", 16'(pe_m), 16'(m_perr));
    chk("parity_err_l", 16'(pe_l), 16'(m_perr));
`endif
  endtask

  // entered just after a falling edge; leaves at the next falling edge with outputs checked
  task automatic cyc(input bit v, input bit b, input bit pr, input bit cl);
    ser_valid = v; ser_in = b; par_ready = pr; clear = cl;
    #1;
    chk("ser_ready_m", 16'(rdy_m), 16'(m_ready()));
    chk("ser_ready_l", 16'(rdy_l), 16'(m_ready()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [8:0] wbits(input logic [7:0] w, input bit par);
    return (NB == 9) ? {w, par} : {1'b0, w};
  endfunction

  task automatic send(input logic [8:0] bits, input bit pr);
    for (int i = NB - 1; i >= 0; i--) cyc(1'b1, bits[i], pr, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_ser_ready", 16'(rdy_m), 16'd1);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    // 11110000 stream with constant valid and par_ready
    send(wbits(8'hF0, 1'b0), 1'b1);
    chk("w_f0_valid", 16'(pv_m), 16'd1);
    chk("w_f0_msb", 16'(po_m), 16'hF0);
    chk("w_f0_lsb", 16'(po_l), 16'h0F);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w_f0_one_cycle", 16'(pv_m), 16'd0);
    // backpressure: A5 held while 3C assembles, last bit stalls
    send(wbits(8'hA5, 1'b0), 1'b0);
    for (int i = NB - 1; i >= 1; i--) cyc(1'b1, wbits(8'h3C, 1'b0)[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, wbits(8'h3C, 1'b0)[0], 1'b0, 1'b0);
    chk("bp_ready_low", 16'(rdy_m), 16'd0);
    chk("bp_hold_a5", 16'(po_m), 16'hA5);
    chk("bp_cnt", 16'(cnt_m), 16'(NB - 1));
    cyc(1'b1, wbits(8'h3C, 1'b0)[0], 1'b1, 1'b0);
    chk("bp_3c", 16'(po_m), 16'h3C);
    chk("bp_3c_valid", 16'(pv_m), 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    // clear after 3 bits, offered bit discarded
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt", 16'(cnt_m), 16'd0);
    send(wbits(8'hC3, 1'b0), 1'b1);
    chk("clr_c3", 16'(po_m), 16'hC3);
    chk("clr_c3_valid", 16'(pv_m), 16'd1);
    // asynchronous reset after 5 bits of a word
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i), 1'b1, 1'b0);
    ser_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt", 16'(cnt_m), 16'd0);
    chk("arst_out", 16'(po_m), 16'd0);
    chk("arst_valid", 16'(pv_m), 16'd0);
    chk("arst_ready", 16'(rdy_m), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(wbits(8'h96, 1'b0), 1'b1);
    chk("arst_word", 16'(po_m), 16'h96);
`ifdef DESER_PARITY_EN
    send(wbits(8'h01, 1'b1), 1'b1);
    chk("par_ok", 16'(pe_m), 16'd0);
    send(wbits(8'h01, 1'b0), 1'b1);
    chk("par_bad", 16'(pe_m), 16'd1);
    chk("par_bad_data", 16'(po_m), 16'h01);
`endif
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 24) == 0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
